// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter:
// FSM state encoding, field widths, field bundle struct and NOP default.
package alu_arb_pkg;

   localparam int REG_W = 3;
   localparam int IMM_W = 16;
   localparam int OP_W  = 8;
   localparam int CNT_W = 8;

   localparam logic [OP_W-1:0] NOP_OP_DEF = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } state_t;

   typedef struct packed {
      logic [REG_W-1:0] a_reg;
      logic [REG_W-1:0] b_reg;
      logic [REG_W-1:0] dest_reg;
      logic [IMM_W-1:0] immediate;
      logic             immediate_p;
      logic [OP_W-1:0]  alu_op;
   } fields_t;

   function automatic fields_t nop_fields(input logic [OP_W-1:0] op);
      fields_t f;
      f        = '0;
      f.alu_op = op;
      return f;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester/arbiter bundle: per-requester req/lock/fields in,
// grants, muxed fields to alu_regfile and lock_err out.
interface alu_arbiter_if;
   import alu_arb_pkg::*;

   logic             req0;
   logic             req1;
   logic             lock0;
   logic             lock1;
   logic [REG_W-1:0] a_reg0;
   logic [REG_W-1:0] b_reg0;
   logic [REG_W-1:0] dest_reg0;
   logic [IMM_W-1:0] immediate0;
   logic             immediate_p0;
   logic [OP_W-1:0]  alu_op0;
   logic [REG_W-1:0] a_reg1;
   logic [REG_W-1:0] b_reg1;
   logic [REG_W-1:0] dest_reg1;
   logic [IMM_W-1:0] immediate1;
   logic             immediate_p1;
   logic [OP_W-1:0]  alu_op1;

   logic             gnt0;
   logic             gnt1;
   logic [REG_W-1:0] a_reg;
   logic [REG_W-1:0] b_reg;
   logic [REG_W-1:0] dest_reg;
   logic [IMM_W-1:0] immediate;
   logic             immediate_p;
   logic [OP_W-1:0]  alu_op;
   logic             lock_err;

   modport master (
      output req0, req1, lock0, lock1,
      output a_reg0, b_reg0, dest_reg0,
      output immediate0, immediate_p0, alu_op0,
      output a_reg1, b_reg1, dest_reg1,
      output immediate1, immediate_p1, alu_op1,
      input  gnt0, gnt1,
      input  a_reg, b_reg, dest_reg,
      input  immediate, immediate_p, alu_op,
      input  lock_err
   );

   modport slave (
      input  req0, req1, lock0, lock1,
      input  a_reg0, b_reg0, dest_reg0,
      input  immediate0, immediate_p0, alu_op0,
      input  a_reg1, b_reg1, dest_reg1,
      input  immediate1, immediate_p1, alu_op1,
      output gnt0, gnt1,
      output a_reg, b_reg, dest_reg,
      output immediate, immediate_p, alu_op,
      output lock_err
   );

endinterface

// File: rtl/alu_arb_mux.sv
// Field multiplexer: i_sel one-hot grant, i_f0/i_f1 requester fields,
// o_f selected fields, or NOP fields when nothing is granted.
module alu_arb_mux
   import alu_arb_pkg::*;
#(
   parameter logic [OP_W-1:0] NOP_OP = NOP_OP_DEF
) (
   input  logic [1:0] i_sel,
   input  fields_t    i_f0,
   input  fields_t    i_f1,
   output fields_t    o_f
);

   always_comb begin
      o_f = nop_fields(NOP_OP);
      unique case (1'b1)
         i_sel[0]: o_f = i_f0;
         i_sel[1]: o_f = i_f1;
         default:  ;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester datapath arbiter with round-robin and bounded locks.
// Ports: clk, reset (async active-low), bus (alu_arbiter_if.slave).
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int              MAX_LOCK = 8,
   parameter logic [OP_W-1:0] NOP_OP   = NOP_OP_DEF
) (
   input  logic          clk,
   input  logic          reset,
   alu_arbiter_if.slave  bus
);

   localparam logic [CNT_W-1:0] LMAX = CNT_W'(MAX_LOCK);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_prio;
   logic             w_prio_nxt;
   logic [CNT_W-1:0] r_lcnt;
   logic [CNT_W-1:0] w_lcnt_nxt;
   logic             r_lock_err;
   logic             w_err_nxt;
   logic [1:0]       w_pick;
   logic [1:0]       w_gnt;
   logic             w_own;
   logic             w_own_req;
   logic             w_own_lock;
   logic             w_oth_req;
   fields_t          w_f0;
   fields_t          w_f1;
   fields_t          w_fo;

   // In a lock state, "own" is the lock holder, "oth" the other side.
   assign w_own      = (r_state == ST_LOCK1);
   assign w_own_req  = w_own ? bus.req1  : bus.req0;
   assign w_own_lock = w_own ? bus.lock1 : bus.lock0;
   assign w_oth_req  = w_own ? bus.req0  : bus.req1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_prio     <= 1'b0;
         r_lcnt     <= '0;
         r_lock_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_prio     <= w_prio_nxt;
         r_lcnt     <= w_lcnt_nxt;
         r_lock_err <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_prio_nxt  = r_prio;
      w_lcnt_nxt  = r_lcnt;
      w_err_nxt   = 1'b0;
      w_pick      = 2'b00;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.req0 && bus.req1)
               w_pick = r_prio ? 2'b10 : 2'b01;
            else
               w_pick = {bus.req1, bus.req0};
            if (w_pick[0]) begin
               if (bus.lock0) begin
                  w_state_nxt = ST_LOCK0;
                  w_lcnt_nxt  = CNT_W'(1);
               end else begin
                  w_prio_nxt = 1'b1;
               end
            end else if (w_pick[1]) begin
               if (bus.lock1) begin
                  w_state_nxt = ST_LOCK1;
                  w_lcnt_nxt  = CNT_W'(1);
               end else begin
                  w_prio_nxt = 1'b0;
               end
            end
         end
         ST_LOCK0, ST_LOCK1: begin
            w_pick = w_own ? {w_own_req, 1'b0}
                           : {1'b0, w_own_req};
            if (!(w_own_req && w_own_lock)) begin
               w_state_nxt = ST_IDLE;
               w_prio_nxt  = !w_own;
               w_lcnt_nxt  = '0;
            end else if (r_lcnt < LMAX) begin
               w_lcnt_nxt = r_lcnt + CNT_W'(1);
            end else if (w_oth_req) begin
               // Lock held to the limit while contended: break it.
               w_state_nxt = ST_IDLE;
               w_prio_nxt  = !w_own;
               w_lcnt_nxt  = '0;
               w_err_nxt   = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Grants are combinational, so they must also be masked while
   // reset is asserted, not just after the next clock.
   assign w_gnt = w_pick & {2{reset}};

   assign w_f0 = {bus.a_reg0, bus.b_reg0, bus.dest_reg0,
                  bus.immediate0, bus.immediate_p0, bus.alu_op0};
   assign w_f1 = {bus.a_reg1, bus.b_reg1, bus.dest_reg1,
                  bus.immediate1, bus.immediate_p1, bus.alu_op1};

   alu_arb_mux #(
      .NOP_OP (NOP_OP)
   ) u_mux (
      .i_sel (w_gnt),
      .i_f0  (w_f0),
      .i_f1  (w_f1),
      .o_f   (w_fo)
   );

   assign bus.gnt0        = w_gnt[0];
   assign bus.gnt1        = w_gnt[1];
   assign bus.a_reg       = w_fo.a_reg;
   assign bus.b_reg       = w_fo.b_reg;
   assign bus.dest_reg    = w_fo.dest_reg;
   assign bus.immediate   = w_fo.immediate;
   assign bus.immediate_p = w_fo.immediate_p;
   assign bus.alu_op      = w_fo.alu_op;
   assign bus.lock_err    = r_lock_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, reset
// sequences and randomized traffic against a behavioural model.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int              ML  = 4;
   localparam logic [OP_W-1:0] NOP = 8'hF0;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   alu_arbiter_if bus();

   alu_arbiter #(
      .MAX_LOCK (ML),
      .NOP_OP   (NOP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   fields_t f0;
   fields_t f1;

   // Model: owner of a lock (-1 none), cycles held, turn, pending error.
   int m_own  = -1;
   int m_held = 0;
   int m_turn = 0;
   bit m_err  = 1'b0;

   typedef struct {
      bit       r0;
      bit       r1;
      bit       l0;
      bit       l1;
      bit [1:0] g;
      bit       err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit r0, bit r1, bit l0, bit l1,
                               bit [1:0] g, bit err);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1;
      v.g = g; v.err = err;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit r0, input bit r1,
                        input bit l0, input bit l1);
      bus.req0 = r0;  bus.req1 = r1;
      bus.lock0 = l0; bus.lock1 = l1;
      {bus.a_reg0, bus.b_reg0, bus.dest_reg0, bus.immediate0,
       bus.immediate_p0, bus.alu_op0} = f0;
      {bus.a_reg1, bus.b_reg1, bus.dest_reg1, bus.immediate1,
       bus.immediate_p1, bus.alu_op1} = f1;
   endtask

   function automatic logic [36:0] pack_exp(int g, bit err);
      fields_t f;
      if (g == 0) f = f0;
      else if (g == 1) f = f1;
      else begin
         f = '0;
         f.alu_op = NOP;
      end
      return {g == 1, g == 0, f, err};
   endfunction

   function automatic logic [36:0] pack_act();
      return {bus.gnt1, bus.gnt0, bus.a_reg, bus.b_reg,
              bus.dest_reg, bus.immediate, bus.immediate_p,
              bus.alu_op, bus.lock_err};
   endfunction

   function automatic int m_grant(bit r0, bit r1);
      if (m_own < 0) begin
         if (r0 && r1) return m_turn;
         if (r0) return 0;
         if (r1) return 1;
         return -1;
      end
      if (m_own == 0) return r0 ? 0 : -1;
      return r1 ? 1 : -1;
   endfunction

   task automatic m_step(input bit r0, input bit r1,
                         input bit l0, input bit l1, input int g);
      bit r[2];
      bit l[2];
      int o;
      r = '{r0, r1};
      l = '{l0, l1};
      m_err = 1'b0;
      if (m_own < 0) begin
         if (g >= 0) begin
            if (l[g]) begin
               m_own  = g;
               m_held = 1;
            end else begin
               m_turn = 1 - g;
            end
         end
      end else begin
         o = m_own;
         if (!(r[o] && l[o])) begin
            m_own  = -1;
            m_turn = 1 - o;
         end else if (m_held < ML) begin
            m_held++;
         end else if (r[1-o]) begin
            m_own  = -1;
            m_turn = 1 - o;
            m_err  = 1'b1;
         end
      end
   endtask

   task automatic m_reset();
      m_own = -1; m_held = 0; m_turn = 0; m_err = 1'b0;
   endtask

   task automatic cyc(input string name, input bit r0, input bit r1,
                      input bit l0, input bit l1, input bit use_tbl,
                      input bit [1:0] tg, input bit terr);
      int g;
      int eg;
      logic [36:0] e;
      @(negedge clk);
      drive(r0, r1, l0, l1);
      #2;
      g = m_grant(r0, r1);
      if (use_tbl) begin
         eg = (tg == 2'b01) ? 0 : (tg == 2'b10) ? 1 : -1;
         e  = pack_exp(eg, terr);
      end else begin
         e = pack_exp(g, m_err);
      end
      check(name, 64'(pack_act()), 64'(e));
      m_step(r0, r1, l0, l1, g);
   endtask

   initial begin
      logic [63:0] rv;
      bit r0, r1, l0, l1;

      f0 = {3'd1, 3'd2, 3'd3, 16'h1234, 1'b1, 8'h05};
      f1 = {3'd4, 3'd5, 3'd6, 16'hBEEF, 1'b0, 8'h0A};
      drive(1, 1, 1, 1);
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 check("reset_hold", 64'(pack_act()), 64'(pack_exp(-1, 0)));
      end
      @(posedge clk);
      #1 reset = 1'b1;
      m_reset();

      // idle, then contention alternation, then lone req0
      repeat (5) tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0));
      tbl.push_back(mk(1, 1, 0, 0, 2'b01, 0));
      tbl.push_back(mk(1, 1, 0, 0, 2'b10, 0));
      tbl.push_back(mk(1, 1, 0, 0, 2'b01, 0));
      tbl.push_back(mk(1, 1, 0, 0, 2'b10, 0));
      tbl.push_back(mk(1, 0, 0, 0, 2'b01, 0));
      tbl.push_back(mk(1, 1, 0, 0, 2'b10, 0));
      // lock for three cycles then release
      repeat (3) tbl.push_back(mk(1, 1, 1, 0, 2'b01, 0));
      tbl.push_back(mk(1, 1, 0, 0, 2'b01, 0));
      tbl.push_back(mk(1, 1, 0, 0, 2'b10, 0));
      // lock forced off at the limit
      repeat (5) tbl.push_back(mk(1, 1, 1, 0, 2'b01, 0));
      tbl.push_back(mk(1, 1, 1, 0, 2'b10, 1));
      tbl.push_back(mk(1, 1, 1, 0, 2'b01, 0));
      // uncontended lock saturates, then contention breaks it
      repeat (5) tbl.push_back(mk(1, 0, 1, 0, 2'b01, 0));
      tbl.push_back(mk(1, 1, 1, 0, 2'b01, 0));
      tbl.push_back(mk(0, 1, 0, 0, 2'b10, 1));
      tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0));
      // lock by requester 1, other request ignored
      tbl.push_back(mk(0, 1, 0, 1, 2'b10, 0));
      tbl.push_back(mk(1, 1, 0, 1, 2'b10, 0));
      tbl.push_back(mk(1, 1, 0, 0, 2'b10, 0));
      tbl.push_back(mk(1, 1, 0, 0, 2'b01, 0));
      // holder drops req while locked: nobody granted
      tbl.push_back(mk(1, 0, 1, 0, 2'b01, 0));
      tbl.push_back(mk(0, 1, 0, 0, 2'b00, 0));
      tbl.push_back(mk(0, 1, 0, 0, 2'b10, 0));

      foreach (tbl[i])
         cyc($sformatf("tbl%0d", i), tbl[i].r0, tbl[i].r1,
             tbl[i].l0, tbl[i].l1, 1'b1, tbl[i].g, tbl[i].err);

      // reset while requester 1 holds a lock
      cyc("lk1_enter", 0, 1, 0, 1, 1'b1, 2'b10, 0);
      cyc("lk1_hold", 1, 1, 0, 1, 1'b1, 2'b10, 0);
      @(negedge clk);
      reset = 1'b0;
      #1 check("rst_midlock", 64'(pack_act()), 64'(pack_exp(-1, 0)));
      m_reset();
      @(negedge clk);
      #1 check("rst_midlock2", 64'(pack_act()), 64'(pack_exp(-1, 0)));
      @(posedge clk);
      #1 reset = 1'b1;
      cyc("rst_first", 1, 1, 0, 0, 1'b1, 2'b01, 0);
      cyc("rst_second", 1, 1, 0, 0, 1'b1, 2'b10, 0);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         rv = {$urandom(), $urandom()};
         f0 = rv[33:0];
         rv = {$urandom(), $urandom()};
         f1 = rv[33:0];
         r0 = ($urandom_range(99) < 85);
         r1 = ($urandom_range(99) < 85);
         l0 = ($urandom_range(99) < 80);
         l1 = ($urandom_range(99) < 80);
         cyc("rand", r0, r1, l0, l1, 1'b0, 2'b00, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
